ws2812b_rx: RTL

WS2812B serial-line receiver: the decode end of the single-wire protocol our transmitter chain drives from the rotation/generator handshake. It samples the LED data line at 100 MHz, classifies high-pulse widths as 0/1, assembles 24-bit GRB pixel words MSB-first, and flags end-of-frame on the reset-low interval. It is used for on-board loopback checking of the TX path and for bench self-checking.

---
 rtl/ws2812b_pkg.sv | 26 ++
 rtl/ws2812b_rx_sync.sv | 53 +++++
 rtl/ws2812b_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B line constants and receiver state encodings.
// The transmitter side uses the same timing values.
package ws2812b_pkg;

  localparam int T0H          = 40;
  localparam int T1H          = 80;
  localparam int T_BIT        = 125;
  localparam int T_RESET      = 5000;
  localparam int T_BIT_THRESH = 60;
  localparam int T_HIGH_MIN   = 20;
  localparam int T_HIGH_MAX   = 100;
  localparam int WORD_W       = 24;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  typedef enum logic [1:0] {
    SYNC = ST_SYNC,
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    LOW  = ST_LOW
  } rxState_t;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Synchronizes the raw data line and emits registered rise/fall strobes.
// WS2812B_RX_GLITCH_FILTER_EN adds a 3-cycle stability filter before edge detection.
module ws2812b_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic syncMeta;
  logic syncOut;
  logic accept;

`ifdef WS2812B_RX_GLITCH_FILTER_EN
  logic [1:0] stableCnt;

  // A new level is taken on its third consecutive cycle; 1-2 cycle blips never reach `level`.
  assign accept = (syncOut != level) && (stableCnt == 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stableCnt <= 2'd0;
    end else if ((syncOut == level) || accept) begin
      stableCnt <= 2'd0;
    end else begin
      stableCnt <= stableCnt + 2'd1;
    end
  end
`else
  assign accept = (syncOut != level);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      syncMeta <= din;
      syncOut  <= syncMeta;
      if (accept) begin
        level <= syncOut;
      end
      rise <= accept & syncOut;
      fall <= accept & ~syncOut;
    end
  end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B line receiver: pulse-width bit decode, 24-bit GRB word assembly, frame reset detect.
// Build with WS2812B_RX_GLITCH_FILTER_EN to filter short line glitches (adds 2 cycles latency).
//
// state | meaning
// SYNC  | waiting for a full reset-low interval before trusting the line
// IDLE  | frame boundary seen, waiting for the first rising edge
// HIGH  | measuring a high pulse
// LOW   | measuring the low gap after a bit
module ws2812b_rx #(
  parameter int T_BIT_THRESH = ws2812b_pkg::T_BIT_THRESH,
  parameter int T_HIGH_MIN   = ws2812b_pkg::T_HIGH_MIN,
  parameter int T_HIGH_MAX   = ws2812b_pkg::T_HIGH_MAX,
  parameter int T_RESET      = ws2812b_pkg::T_RESET,
  parameter int IDX_W        = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              din,
  output logic [ws2812b_pkg::WORD_W-1:0]    pixel_data,
  output logic                              pixel_valid,
  output logic [IDX_W-1:0]                  pixel_index,
  output logic                              frame_done,
  output logic                              proto_err
);

  import ws2812b_pkg::*;

  localparam logic [6:0]  HCNT_SAT  = 7'd127;
  localparam logic [12:0] LCNT_LAST = 13'(T_RESET - 1);

  rxState_t            state, stateNext;
  logic [6:0]          hcnt, hcntNext;
  logic [12:0]         lcnt, lcntNext;
  logic [4:0]          bitCnt, bitCntNext;
  logic [WORD_W-1:0]   shiftReg, shiftNext, shifted;
  logic [IDX_W-1:0]    wordIdx, wordIdxNext, idxNext;
  logic [WORD_W-1:0]   dataNext;
  logic                validNext, frameNext, errNext;
  logic                lineLevel, lineRise, lineFall;
  logic                bitIn, pulseBad, lastBit, lowDone;

  ws2812b_rx_sync uSync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .level (lineLevel),
    .rise  (lineRise),
    .fall  (lineFall)
  );

  assign bitIn    = (hcnt >= 7'(T_BIT_THRESH));
  assign pulseBad = (hcnt < 7'(T_HIGH_MIN)) || (hcnt > 7'(T_HIGH_MAX));
  assign shifted  = {shiftReg[WORD_W-2:0], bitIn};
  assign lastBit  = (bitCnt == 5'(WORD_W - 1));
  assign lowDone  = (lcnt >= LCNT_LAST);

  always_comb begin
    stateNext   = state;
    hcntNext    = hcnt;
    lcntNext    = lcnt;
    bitCntNext  = bitCnt;
    shiftNext   = shiftReg;
    wordIdxNext = wordIdx;
    dataNext    = pixel_data;
    idxNext     = pixel_index;
    validNext   = 1'b0;
    frameNext   = 1'b0;
    errNext     = 1'b0;

    case (state)
      SYNC: begin
        if (lineLevel) begin
          lcntNext = 13'd0;
        end else if (lowDone) begin
          lcntNext  = 13'(T_RESET);
          stateNext = IDLE;
        end else begin
          lcntNext = lcnt + 13'd1;
        end
      end

      IDLE: begin
        if (lineRise) begin
          hcntNext  = 7'd1;
          stateNext = HIGH;
        end
      end

      HIGH: begin
        if (lineFall) begin
          if (pulseBad) begin
            errNext     = 1'b1;
            shiftNext   = '0;
            bitCntNext  = 5'd0;
            wordIdxNext = '0;
            idxNext     = '0;
            lcntNext    = 13'd0;
            stateNext   = SYNC;
          end else begin
            lcntNext  = 13'd1;
            stateNext = LOW;
            if (lastBit) begin
              dataNext    = shifted;
              validNext   = 1'b1;
              idxNext     = wordIdx;
              wordIdxNext = wordIdx + IDX_W'(1);
              shiftNext   = '0;
              bitCntNext  = 5'd0;
            end else begin
              shiftNext  = shifted;
              bitCntNext = bitCnt + 5'd1;
            end
          end
        end else if (hcnt != HCNT_SAT) begin
          hcntNext = hcnt + 7'd1;
        end
      end

      LOW: begin
        // A rise on the last counted low cycle still continues the frame.
        if (lineRise) begin
          hcntNext  = 7'd1;
          stateNext = HIGH;
        end else if (lowDone) begin
          frameNext   = 1'b1;
          errNext     = (bitCnt != 5'd0);
          shiftNext   = '0;
          bitCntNext  = 5'd0;
          wordIdxNext = '0;
          idxNext     = '0;
          lcntNext    = 13'(T_RESET);
          stateNext   = IDLE;
        end else begin
          lcntNext = lcnt + 13'd1;
        end
      end

      default: stateNext = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      hcnt        <= 7'd0;
      lcnt        <= 13'd0;
      bitCnt      <= 5'd0;
      shiftReg    <= '0;
      wordIdx     <= '0;
      pixel_data  <= '0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= stateNext;
      hcnt        <= hcntNext;
      lcnt        <= lcntNext;
      bitCnt      <= bitCntNext;
      shiftReg    <= shiftNext;
      wordIdx     <= wordIdxNext;
      pixel_data  <= dataNext;
      pixel_index <= idxNext;
      pixel_valid <= validNext;
      frame_done  <= frameNext;
      proto_err   <= errNext;
    end
  end

endmodule
